// File: rtl/bit_tx_pkg.sv
// Shared types and default sizing for the bit_tx serial transmitter.
// Imported by bit_timer and bit_tx.
package bit_tx_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// The wrap pulse marks the last cycle of each serial bit.
module bit_timer
    import bit_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    output logic wrap
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Held at zero when disabled so every frame starts aligned.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bit_tx.sv
// Serial transmitter: start bit, LSB-first data, even parity, stop bit.
// Word is latched and the start bit driven on the accepting edge.
module bit_tx
    import bit_tx_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data,
    input  logic              Valid,
    output logic              Ready,
    output logic              Q,
    output logic              Qbar,
    output logic              Busy,
    output logic              Done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic               par;
    logic [IDX_W-1:0]   idx;
    logic               q_r;
    logic               done_r;
    logic               wrap;

    assign Ready = (state == IDLE);
    assign Busy  = ~Ready;
    assign Q     = q_r;
    assign Qbar  = ~q_r;
    assign Done  = done_r;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .Clk  (Clk),
        .Reset(Reset),
        .en   (Busy),
        .wrap (wrap)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            shreg  <= '0;
            par    <= 1'b0;
            idx    <= '0;
            q_r    <= 1'b1;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Valid) begin
                        shreg <= Data;
                        par   <= ^Data;
                        idx   <= '0;
                        q_r   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (wrap) begin
                        q_r   <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                // shreg[0] always holds the next bit to put on the line.
                DATA: begin
                    if (wrap) begin
                        if (idx == LAST_IDX) begin
                            q_r   <= par;
                            state <= PARITY;
                        end else begin
                            q_r   <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (wrap) begin
                        q_r   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_tx.sv
// Scoreboard bench for bit_tx: stimulus queues accepted words,
// a monitor captures each frame from Q and checks it on Done.
module tb_bit_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int NB  = DW + 3;

    logic          Clk;
    logic          Reset;
    logic [DW-1:0] Data;
    logic          Valid;
    logic          Ready;
    logic          Q;
    logic          Qbar;
    logic          Busy;
    logic          Done;

    int vectors;
    int miscompares;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pending[$];
    logic          cur[$];
    logic          hold;

    bit_tx #(
        .DATA_W(DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Data (Data),
        .Valid(Valid),
        .Ready(Ready),
        .Q    (Q),
        .Qbar (Qbar),
        .Busy (Busy),
        .Done (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference frame: bit k of the serial frame for word w.
    function automatic logic ref_bit(input logic [DW-1:0] w, input int k);
        if (k == 0)  return 1'b0;
        if (k <= DW) return w[k-1];
        if (k == DW + 1) return ^w;
        return 1'b1;
    endfunction

    // Monitor
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(negedge Clk);
            chk("qbar_inv", {31'd0, Qbar}, {31'd0, ~Q});
            chk("busy_inv", {31'd0, Busy}, {31'd0, ~Ready});
            if (!Reset) begin
                cur.delete();
            end else begin
                if (Busy) begin
                    cur.push_back(Q);
                end else if (Q !== 1'b1) begin
                    chk("idle_high", {31'd0, Q}, 32'd1);
                end
                if (Done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", 32'd1, 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("frame_len", cur.size(), NB * CPB);
                        for (int k = 0; k < cur.size() && k < NB * CPB; k++)
                            chk($sformatf("bit_%0h_%0d", w, k),
                                {31'd0, cur[k]},
                                {31'd0, ref_bit(w, k / CPB)});
                    end
                    cur.delete();
                end
            end
        end
    end

    task automatic run_stream(input int max_cycles);
        int n;
        n = 0;
        while ((pending.size() > 0 || Busy || Valid) && n < max_cycles) begin
            @(negedge Clk);
            n++;
            if (Ready) begin
                if (pending.size() > 0 && (hold || $urandom_range(0, 2) != 0)) begin
                    Valid = 1'b1;
                    Data  = pending.pop_front();
                    exp_q.push_back(Data);
                end else begin
                    Valid = 1'b0;
                    Data  = DW'($urandom);
                end
            end else begin
                Valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                Data  = DW'($urandom);
            end
        end
        if (n >= max_cycles) chk("stream_timeout", n, 0);
        Valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hold        = 1'b0;
        Reset       = 1'b0;
        Valid       = 1'b0;
        Data        = '0;

        repeat (3) @(negedge Clk);
        chk("rst_q", {31'd0, Q}, 32'd1);
        chk("rst_qbar", {31'd0, Qbar}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("rst_ready", {31'd0, Ready}, 32'd1);

        pending.push_back(8'hA5);
        pending.push_back(8'h07);
        pending.push_back(8'h00);
        run_stream(400);
        repeat (2) @(negedge Clk);
        chk("idle_busy", {31'd0, Busy}, 32'd0);

        hold = 1'b1;
        pending.push_back(8'h3C);
        pending.push_back(8'hC3);
        run_stream(400);
        hold = 1'b0;
        repeat (2) @(negedge Clk);

        // Abort a 0xFF frame partway through.
        @(negedge Clk);
        Valid = 1'b1;
        Data  = 8'hFF;
        @(negedge Clk);
        Valid = 1'b0;
        chk("ff_started", {31'd0, Busy}, 32'd1);
        repeat (18) @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_q", {31'd0, Q}, 32'd1);
        chk("abort_qbar", {31'd0, Qbar}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (60) @(negedge Clk);
        pending.push_back(8'h55);
        run_stream(200);

        for (int i = 0; i < 30; i++) pending.push_back(DW'($urandom));
        run_stream(4000);
        repeat (3) @(negedge Clk);

        chk("frames_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
